// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer: byte-address to word-access conversion, lane extraction,
// read-modify-write for sub-word stores, alignment rejection and access timeout.
module lsu_mem_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [2:0]     op_r;
  logic [1:0]     off_r;
  logic [15:0]    wdata_r;
  logic [CW-1:0]  tmo_cnt_r;
  logic           accept_s;
  logic           expire_s;
  logic           is_store_s;

  function automatic logic misaligned(input logic [2:0] op, input logic [1:0] a);
    case (op)
      3'd1, 3'd4, 3'd6: misaligned = a[0];
      3'd2, 3'd7:       misaligned = (a != 2'b00);
      default:          misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (op)
      3'd0:    load_extract = {{24{b[7]}}, b};
      3'd1:    load_extract = {{16{h[15]}}, h};
      3'd3:    load_extract = {24'h000000, b};
      3'd4:    load_extract = {16'h0000, h};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] word, input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (op == 3'd5) begin
      r[{off, 3'b000} +: 8] = wd[7:0];
    end else begin
      r[{off[1], 4'b0000} +: 16] = wd;
    end
    lane_merge = r;
  endfunction

  assign accept_s   = req_valid && (state_r == IDLE);
  assign expire_s   = (tmo_cnt_r == CW'(TIMEOUT - 1));
  assign is_store_s = (op_r >= 3'd5);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; an ack in the expiry cycle takes priority over the timeout
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          state_nxt_s = IDLE;
        end else if (misaligned(req_op, req_addr[1:0])) begin
          state_nxt_s = DONE;
        end else if (req_op == 3'd7) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = READ;
        end
      end
      READ: begin
        if (mem_ack) begin
          state_nxt_s = is_store_s ? WRITE : DONE;
        end else if (expire_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = READ;
        end
      end
      WRITE: begin
        if (mem_ack || expire_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from the state register, so reset clears mem_req immediately
  always_comb begin
    req_ready  = (state_r == IDLE);
    resp_valid = (state_r == DONE);
    mem_req    = (state_r == READ) || (state_r == WRITE);
    mem_we     = (state_r == WRITE);
  end

  // Capture registers, memory address/data, timeout counter and response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r       <= 3'd0;
      off_r      <= 2'd0;
      wdata_r    <= 16'h0000;
      tmo_cnt_r  <= '0;
      mem_addr   <= 32'h0000_0000;
      mem_wdata  <= 32'h0000_0000;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r      <= req_op;
            off_r     <= req_addr[1:0];
            wdata_r   <= req_wdata[15:0];
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= req_wdata;
            tmo_cnt_r <= '0;
            if (misaligned(req_op, req_addr[1:0])) begin
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0000_0000;
            end
          end
        end
        READ: begin
          if (mem_ack) begin
            tmo_cnt_r <= '0;
            if (is_store_s) begin
              mem_wdata <= lane_merge(op_r, off_r, mem_rdata, wdata_r);
            end else begin
              resp_rdata <= load_extract(op_r, off_r, mem_rdata);
              resp_err   <= 1'b0;
            end
          end else if (expire_s) begin
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0000_0000;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
          end
        end
        WRITE: begin
          if (mem_ack) begin
            resp_rdata <= mem_wdata;
            resp_err   <= 1'b0;
          end else if (expire_s) begin
            resp_err   <= 1'b1;
            resp_rdata <= 32'h0000_0000;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
          end
        end
        default: begin
          tmo_cnt_r <= tmo_cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed self-checking bench for lsu_mem_sequencer (TIMEOUT=4) with a
// cycle-driven memory responder and hand-computed expectations.
module tb_lsu_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int failures = 0;

  lsu_mem_sequencer #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one access from a negedge; memory acks after 'wait_cycles' cycles of
  // each request phase (-1 = never). Returns on the negedge after resp_valid.
  task automatic do_access(input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd_word,
                           input int wait_cycles,
                           output int lat, output int req_hi, output int we_cnt,
                           output logic [31:0] maddr, output logic [31:0] wr_word,
                           output logic err, output logic [31:0] rdata,
                           output logic ready_after);
    int cyc;
    int wcnt;
    logic done;
    logic prev_req;
    logic prev_we;
    lat = 0; req_hi = 0; we_cnt = 0; maddr = 32'h0; wr_word = 32'h0;
    err = 1'bx; rdata = 32'hx; done = 1'b0; wcnt = 0;
    prev_req = 1'b0; prev_we = 1'b0;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      mem_ack = 1'b0;
      if (resp_valid) begin
        lat = cyc; err = resp_err; rdata = resp_rdata; done = 1'b1;
      end else if (mem_req) begin
        if (!prev_req || (mem_we != prev_we)) wcnt = 0;
        req_hi++;
        maddr = mem_addr;
        if (mem_we) begin
          wr_word = mem_wdata;
          we_cnt++;
        end
        mem_rdata = rd_word;
        mem_ack = (wait_cycles >= 0) && (wcnt == wait_cycles);
        wcnt++;
      end
      prev_req = mem_req;
      prev_we = mem_we;
      if (!done) begin
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
    end
    mem_ack = 1'b0;
    if (!done) chk("resp_valid_bound", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    ready_after = req_ready;
  endtask

  int lat, req_hi, we_cnt;
  logic [31:0] maddr, wr_word, rdata;
  logic err, rdy;
  logic saw_resp;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0;
    req_wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // LB 0x103, ack first cycle
    do_access(3'd0, 32'h103, 32'h0, 32'h80FF1234, 0, lat, req_hi, we_cnt, maddr, wr_word, err, rdata, rdy);
    chk("lb_maddr", maddr, 32'h100);
    chk("lb_rdata", rdata, 32'hFFFFFF80);
    chk("lb_err", {31'd0, err}, 32'd0);
    chk("lb_lat", lat, 32'd2);
    chk("lb_ready", {31'd0, rdy}, 32'd1);

    // LHU 0x202, three wait cycles
    do_access(3'd4, 32'h202, 32'h0, 32'hBEEF0001, 3, lat, req_hi, we_cnt, maddr, wr_word, err, rdata, rdy);
    chk("lhu_rdata", rdata, 32'h0000BEEF);
    chk("lhu_req_hi", req_hi, 32'd4);
    chk("lhu_lat", lat, 32'd5);

    // SB 0x301 read-modify-write
    do_access(3'd5, 32'h301, 32'h000000AA, 32'h11223344, 0, lat, req_hi, we_cnt, maddr, wr_word, err, rdata, rdy);
    chk("sb_wdata", wr_word, 32'h1122AA44);
    chk("sb_we_cycles", we_cnt, 32'd1);
    chk("sb_rdata", rdata, 32'h1122AA44);
    chk("sb_lat", lat, 32'd3);
    chk("sb_maddr", maddr, 32'h300);

    // Misaligned LW and SH
    do_access(3'd2, 32'h402, 32'h0, 32'h12345678, 0, lat, req_hi, we_cnt, maddr, wr_word, err, rdata, rdy);
    chk("lw_mis_err", {31'd0, err}, 32'd1);
    chk("lw_mis_rdata", rdata, 32'h0);
    chk("lw_mis_req", req_hi, 32'd0);
    chk("lw_mis_lat", lat, 32'd1);
    do_access(3'd6, 32'h403, 32'h1234, 32'h12345678, 0, lat, req_hi, we_cnt, maddr, wr_word, err, rdata, rdy);
    chk("sh_mis_err", {31'd0, err}, 32'd1);
    chk("sh_mis_req", req_hi, 32'd0);
    chk("sh_mis_lat", lat, 32'd1);

    // Timeout on a load, then ack exactly on the last allowed cycle
    do_access(3'd2, 32'h500, 32'h0, 32'h0, -1, lat, req_hi, we_cnt, maddr, wr_word, err, rdata, rdy);
    chk("tmo_req_hi", req_hi, 32'd4);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_rdata", rdata, 32'h0);
    do_access(3'd2, 32'h504, 32'h0, 32'hCAFEF00D, 3, lat, req_hi, we_cnt, maddr, wr_word, err, rdata, rdy);
    chk("ack_last_err", {31'd0, err}, 32'd0);
    chk("ack_last_rdata", rdata, 32'hCAFEF00D);

    // Sub-word store aborted in READ never writes
    do_access(3'd6, 32'h600, 32'h5555, 32'h0, -1, lat, req_hi, we_cnt, maddr, wr_word, err, rdata, rdy);
    chk("sh_tmo_we", we_cnt, 32'd0);
    chk("sh_tmo_err", {31'd0, err}, 32'd1);

    // More extraction / store patterns
    do_access(3'd1, 32'h700, 32'h0, 32'h12348001, 1, lat, req_hi, we_cnt, maddr, wr_word, err, rdata, rdy);
    chk("lh_rdata", rdata, 32'hFFFF8001);
    do_access(3'd3, 32'h702, 32'h0, 32'h12F45678, 0, lat, req_hi, we_cnt, maddr, wr_word, err, rdata, rdy);
    chk("lbu_rdata", rdata, 32'h000000F4);
    do_access(3'd7, 32'h800, 32'hDEADBEEF, 32'h0, 0, lat, req_hi, we_cnt, maddr, wr_word, err, rdata, rdy);
    chk("sw_wdata", wr_word, 32'hDEADBEEF);
    chk("sw_rdata", rdata, 32'hDEADBEEF);
    chk("sw_lat", lat, 32'd2);
    do_access(3'd6, 32'h802, 32'h00005555, 32'hAABBCCDD, 2, lat, req_hi, we_cnt, maddr, wr_word, err, rdata, rdy);
    chk("sh_wdata", wr_word, 32'h5555CCDD);
    chk("sh_rdata", rdata, 32'h5555CCDD);

    // Reset in the middle of an SW write phase
    req_valid = 1'b1; req_op = 3'd7; req_addr = 32'h900; req_wdata = 32'h01020304;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_sw_req", {31'd0, mem_req}, 32'd1);
    chk("rst_sw_we", {31'd0, mem_we}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_async_req", {31'd0, mem_req}, 32'd0);
    saw_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    rst = 1'b0;
    @(negedge clk);
    if (resp_valid) saw_resp = 1'b1;
    chk("rst_no_resp", {31'd0, saw_resp}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    do_access(3'd2, 32'hA00, 32'h0, 32'h0BADC0DE, 0, lat, req_hi, we_cnt, maddr, wr_word, err, rdata, rdy);
    chk("post_rst_rdata", rdata, 32'h0BADC0DE);
    chk("post_rst_err", {31'd0, err}, 32'd0);
    chk("post_rst_lat", lat, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
